// File: rtl/bcd_pulse_gen.sv
// Loads a BCD count and emits that many active-low pulses on P_n, counting REM down
// one BCD step on every falling edge of P_n. All outputs are registered.
module bcd_pulse_gen #(
  parameter int DIGITS     = 2,
  parameter int PULSE_LOW  = 1,
  parameter int PULSE_HIGH = 1
) (
  input  logic                CP,
  input  logic                R0,
  input  logic                LD,
  input  logic                STOP,
  input  logic [4*DIGITS-1:0] D,
  output logic                P_n,
  output logic [4*DIGITS-1:0] REM,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR
);

  localparam int W    = 4 * DIGITS;
  localparam int TMAX = (PULSE_LOW > PULSE_HIGH) ? PULSE_LOW : PULSE_HIGH;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] LOW_LAST  = TW'(PULSE_LOW - 1);
  localparam logic [TW-1:0] HIGH_LAST = TW'(PULSE_HIGH - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, FIN} state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [W-1:0]  rem_reg, rem_next;
  logic          p_n_reg, p_n_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;

  // One shared BCD decrementer: fed from D on a load, from REM while running.
  logic [W-1:0]      dec_src;
  logic [W-1:0]      dec_out;
  logic [DIGITS:0]   borrow;
  logic [DIGITS-1:0] digit_bad;

  assign dec_src   = (state_reg == HIGH) ? rem_reg : D;
  assign borrow[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] dig;
      assign dig            = dec_src[4*gi +: 4];
      assign digit_bad[gi]  = (D[4*gi +: 4] > 4'd9);
      assign borrow[gi+1]   = borrow[gi] && (dig == 4'd0);
      assign dec_out[4*gi +: 4] = !borrow[gi]    ? dig :
                                  (dig == 4'd0)  ? 4'd9 : dig - 4'd1;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    rem_next   = rem_reg;
    p_n_next   = 1'b1;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE, FIN: begin
        state_next = IDLE;
        timer_next = '0;
        if (LD) begin
          if (|digit_bad) begin
            err_next = 1'b1;
          end else if (D == '0) begin
            state_next = FIN;
            rem_next   = '0;
            done_next  = 1'b1;
          end else begin
            state_next = LOW;
            rem_next   = dec_out;
            p_n_next   = 1'b0;
            busy_next  = 1'b1;
          end
        end
      end
      LOW: begin
        busy_next = 1'b1;
        if (STOP) begin
          state_next = IDLE;
          timer_next = '0;
          busy_next  = 1'b0;
        end else if (timer_reg == LOW_LAST) begin
          state_next = HIGH;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + 1'b1;
          p_n_next   = 1'b0;
        end
      end
      HIGH: begin
        busy_next = 1'b1;
        if (STOP) begin
          state_next = IDLE;
          timer_next = '0;
          busy_next  = 1'b0;
        end else if (timer_reg == HIGH_LAST) begin
          timer_next = '0;
          if (rem_reg != '0) begin
            // REM steps on the same edge that P_n falls
            state_next = LOW;
            rem_next   = dec_out;
            p_n_next   = 1'b0;
          end else begin
            state_next = FIN;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge CP or posedge R0) begin
    if (R0) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      rem_reg   <= '0;
      p_n_reg   <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      rem_reg   <= rem_next;
      p_n_reg   <= p_n_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign P_n  = p_n_reg;
  assign REM  = rem_reg;
  assign BUSY = busy_reg;
  assign DONE = done_reg;
  assign ERR  = err_reg;

endmodule

// File: tb/tb_bcd_pulse_gen.sv
// Bench for bcd_pulse_gen: three instances (short pulses, stretched pulses, one digit
// driving a behavioural 74LS90), REM checked against a queue at every P_n falling edge.
module tb_bcd_pulse_gen;

  logic       clk = 1'b0;
  logic       r0  = 1'b1;

  logic       ld_a = 1'b0, stop_a = 1'b0;
  logic [7:0] d_a  = '0;
  logic       p_n_a, busy_a, done_a, err_a;
  logic [7:0] rem_a;

  logic       ld_b = 1'b0, stop_b = 1'b0;
  logic [7:0] d_b  = '0;
  logic       p_n_b, busy_b, done_b, err_b;
  logic [7:0] rem_b;

  logic       ld_c = 1'b0, stop_c = 1'b0;
  logic [3:0] d_c  = '0;
  logic       p_n_c, busy_c, done_c, err_c;
  logic [3:0] rem_c;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int falls_a = 0, falls_b = 0;
  logic prev_a = 1'b1, prev_b = 1'b1;

  // 74LS90 model: P_n into CP1_n, Qa fed back into CP2_n
  logic       ls90_clr = 1'b1;
  logic       qa;
  logic [2:0] q5;

  always #5 clk = ~clk;

  bcd_pulse_gen #(.DIGITS(2), .PULSE_LOW(1), .PULSE_HIGH(1)) u_a (
    .CP(clk), .R0(r0), .LD(ld_a), .STOP(stop_a), .D(d_a),
    .P_n(p_n_a), .REM(rem_a), .BUSY(busy_a), .DONE(done_a), .ERR(err_a));

  bcd_pulse_gen #(.DIGITS(2), .PULSE_LOW(2), .PULSE_HIGH(3)) u_b (
    .CP(clk), .R0(r0), .LD(ld_b), .STOP(stop_b), .D(d_b),
    .P_n(p_n_b), .REM(rem_b), .BUSY(busy_b), .DONE(done_b), .ERR(err_b));

  bcd_pulse_gen #(.DIGITS(1), .PULSE_LOW(1), .PULSE_HIGH(1)) u_c (
    .CP(clk), .R0(r0), .LD(ld_c), .STOP(stop_c), .D(d_c),
    .P_n(p_n_c), .REM(rem_c), .BUSY(busy_c), .DONE(done_c), .ERR(err_c));

  always @(negedge p_n_c or posedge ls90_clr)
    if (ls90_clr) qa <= 1'b0;
    else          qa <= ~qa;

  always @(negedge qa or posedge ls90_clr)
    if (ls90_clr) q5 <= 3'd0;
    else          q5 <= (q5 == 3'd4) ? 3'd0 : q5 + 3'd1;

  function automatic logic [7:0] to_bcd(input int n);
    logic [7:0] v;
    v[7:4] = 4'(n / 10);
    v[3:0] = 4'(n % 10);
    return v;
  endfunction

  // Scoreboards: every falling P_n edge pops the REM value expected at that edge.
  always @(negedge clk) begin
    if (prev_a && !p_n_a) begin
      logic [7:0] e;
      falls_a++;
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_pulse: rem=%h, required no pulse", rem_a);
      end else begin
        e = q_a.pop_front();
        if (rem_a !== e) begin
          errors++;
          $display("FAIL a_rem_at_fall: got %h required %h", rem_a, e);
        end
      end
    end
    prev_a = p_n_a;
    if (prev_b && !p_n_b) begin
      logic [7:0] e;
      falls_b++;
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_pulse: rem=%h, required no pulse", rem_b);
      end else begin
        e = q_b.pop_front();
        if (rem_b !== e) begin
          errors++;
          $display("FAIL b_rem_at_fall: got %h required %h", rem_b, e);
        end
      end
    end
    prev_b = p_n_b;
  end

  task automatic push_a(input int n);
    for (int i = n - 1; i >= 0; i--) q_a.push_back(to_bcd(i));
  endtask

  task automatic check_queue_a(input string name);
    checks++;
    if (q_a.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d pulses missing, required 0", name, q_a.size());
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({p_n_a, rem_a, busy_a, done_a, err_a} !== {1'b1, 8'h00, 3'b000}) begin
      errors++;
      $display("FAIL reset_state: p_n=%b rem=%h busy=%b done=%b err=%b required 1 00 0 0 0",
               p_n_a, rem_a, busy_a, done_a, err_a);
    end
    r0 = 1'b0;
    ls90_clr = 1'b0;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_basic;
    push_a(3);
    d_a = 8'h03; ld_a = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      ld_a = 1'b0;
      checks++;
      if (p_n_a !== !(cyc == 1 || cyc == 3 || cyc == 5) ||
          busy_a !== (cyc >= 1 && cyc <= 6) || done_a !== (cyc == 7)) begin
        errors++;
        $display("FAIL basic_cycle%0d: p_n=%b busy=%b done=%b required %b %b %b", cyc,
                 p_n_a, busy_a, done_a, !(cyc == 1 || cyc == 3 || cyc == 5),
                 (cyc >= 1 && cyc <= 6), (cyc == 7));
      end
    end
    check_queue_a("basic_pulse_count");
    $display("basic D=03 done");
  endtask

  task automatic test_long;
    int k = 0;
    int done_cyc = 0;
    logic prev = 1'b1;
    for (int i = 9; i >= 0; i--) q_b.push_back(to_bcd(i));
    d_b = 8'h10; ld_b = 1'b1;
    for (int cyc = 1; cyc <= 70 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      ld_b = 1'b0;
      if (prev && !p_n_b) begin
        checks++;
        if (cyc != 1 + 5 * k) begin
          errors++;
          $display("FAIL long_spacing: fall %0d at cycle %0d required %0d", k, cyc, 1 + 5 * k);
        end
        k++;
      end
      prev = p_n_b;
      if (done_b) done_cyc = cyc;
    end
    checks++;
    if (done_cyc != 51 || k != 10 || q_b.size() != 0) begin
      errors++;
      $display("FAIL long_done: done cycle %0d falls %0d left %0d required 51 10 0",
               done_cyc, k, q_b.size());
    end
    $display("long D=10 done at cycle %0d", done_cyc);
  endtask

  task automatic test_err_zero;
    d_a = 8'h1A; ld_a = 1'b1;
    @(negedge clk);
    ld_a = 1'b0;
    checks++;
    if (err_a !== 1'b1 || done_a !== 1'b0 || busy_a !== 1'b0 || rem_a !== 8'h00) begin
      errors++;
      $display("FAIL err_strobe: err=%b done=%b busy=%b rem=%h required 1 0 0 00",
               err_a, done_a, busy_a, rem_a);
    end
    @(negedge clk);
    checks++;
    if (err_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL err_one_cycle: err=%b busy=%b required 0 0", err_a, busy_a);
    end
    d_a = 8'h00; ld_a = 1'b1;
    @(negedge clk);
    ld_a = 1'b0;
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || p_n_a !== 1'b1 || err_a !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b p_n=%b err=%b required 1 0 1 0",
               done_a, busy_a, p_n_a, err_a);
    end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b0) begin
      errors++;
      $display("FAIL zero_done_width: done=%b required 0", done_a);
    end
    repeat (3) @(negedge clk);
    $display("err D=1A and zero D=00 done");
  endtask

  task automatic test_back_to_back;
    int f0 = falls_a;
    int seen = 0;
    push_a(4);
    d_a = 8'h04; ld_a = 1'b1;
    @(negedge clk); ld_a = 1'b0;
    @(negedge clk); d_a = 8'h05; ld_a = 1'b1;
    @(negedge clk); ld_a = 1'b0;
    for (int cyc = 0; cyc < 30 && seen == 0; cyc++) begin
      @(negedge clk);
      if (done_a) seen = 1;
    end
    checks++;
    if (seen == 0 || falls_a - f0 != 4) begin
      errors++;
      $display("FAIL ld_while_busy: done seen %0d falls %0d required 1 4", seen, falls_a - f0);
    end
    check_queue_a("ld_while_busy_queue");
    // LD during the FIN cycle starts the next train on the following edge
    push_a(2);
    d_a = 8'h02; ld_a = 1'b1;
    @(negedge clk);
    ld_a = 1'b0;
    checks++;
    if (p_n_a !== 1'b0 || busy_a !== 1'b1 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL ld_in_fin: p_n=%b busy=%b done=%b required 0 1 0", p_n_a, busy_a, done_a);
    end
    seen = 0;
    for (int cyc = 0; cyc < 20 && seen == 0; cyc++) begin
      @(negedge clk);
      if (done_a) seen = 1;
    end
    checks++;
    if (seen == 0) begin
      errors++;
      $display("FAIL fin_train_done: done seen %0d required 1", seen);
    end
    check_queue_a("fin_train_queue");
    @(negedge clk);
    $display("back-to-back done");
  endtask

  task automatic test_stop;
    int dones = 0;
    q_a.push_back(8'h05);
    q_a.push_back(8'h04);
    d_a = 8'h06; ld_a = 1'b1;
    @(negedge clk); ld_a = 1'b0;
    repeat (3) @(negedge clk);
    stop_a = 1'b1; ld_a = 1'b1; d_a = 8'h09;
    @(negedge clk);
    stop_a = 1'b0; ld_a = 1'b0;
    checks++;
    if (p_n_a !== 1'b1 || busy_a !== 1'b0 || rem_a !== 8'h04 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL stop_abort: p_n=%b busy=%b rem=%h done=%b required 1 0 04 0",
               p_n_a, busy_a, rem_a, done_a);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL stop_no_done: %0d DONE cycles required 0", dones);
    end
    check_queue_a("stop_queue");
    // STOP with LD in IDLE: the load is taken
    q_a.push_back(8'h00);
    d_a = 8'h01; ld_a = 1'b1; stop_a = 1'b1;
    @(negedge clk);
    ld_a = 1'b0; stop_a = 1'b0;
    checks++;
    if (p_n_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL stop_ld_idle: p_n=%b busy=%b required 0 1", p_n_a, busy_a);
    end
    repeat (4) @(negedge clk);
    check_queue_a("stop_ld_idle_queue");
    $display("stop done");
  endtask

  task automatic test_midtrain_reset;
    int f0 = falls_a;
    q_a.push_back(8'h06);
    q_a.push_back(8'h05);
    d_a = 8'h07; ld_a = 1'b1;
    @(negedge clk); ld_a = 1'b0;
    repeat (2) @(negedge clk);
    #2 r0 = 1'b1;
    #1;
    checks++;
    if (p_n_a !== 1'b1 || rem_a !== 8'h00 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: p_n=%b rem=%h busy=%b required 1 00 0", p_n_a, rem_a, busy_a);
    end
    repeat (2) @(negedge clk);
    r0 = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (falls_a - f0 != 2) begin
      errors++;
      $display("FAIL reset_no_more_pulses: falls %0d required 2", falls_a - f0);
    end
    check_queue_a("reset_queue");
    $display("mid-train reset done");
  endtask

  task automatic test_ls90;
    for (int d = 0; d <= 9; d++) begin
      int seen = 0;
      @(negedge clk); ls90_clr = 1'b1;
      @(negedge clk); ls90_clr = 1'b0;
      d_c = 4'(d); ld_c = 1'b1;
      for (int cyc = 0; cyc < 40 && seen == 0; cyc++) begin
        @(negedge clk);
        ld_c = 1'b0;
        if (done_c) seen = 1;
      end
      checks++;
      if (seen == 0 || {q5, qa} !== 4'(d)) begin
        errors++;
        $display("FAIL ls90_count: done seen %0d counter %0d required %0d", seen, {q5, qa}, d);
      end else begin
        $display("ls90 D=%0d counter=%0d", d, {q5, qa});
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_long;
    test_err_zero;
    test_back_to_back;
    test_stop;
    test_midtrain_reset;
    test_ls90;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
